// File: rtl/nf_i_fu_pkg.sv
// Shared fetch/decode settings.
//   fu_state_t   : fetch FSM state (REQ issues a read, HOLD parks a fetched word)
//   NOP_INSTR_C  : bubble instruction (ADDI x0,x0,0) seen by the decoder
//   RESET_PC_C   : default first fetch address
package nf_i_fu_pkg;

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } fu_state_t;

    localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;

    // Redirect targets are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/nf_i_fu_skid.sv
// Skid register for one fetched word while decode is stalled.
//   clk        : clock
//   clear      : synchronous clear (dominates load)
//   load       : capture instr_in/pc_in
//   instr_in   : fetched instruction
//   pc_in      : its address
//   instr      : held instruction
//   pc         : held address
//   valid      : holding a word
module nf_i_fu_skid
    import nf_i_fu_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (clear) begin
            instr <= NOP_INSTR_C;
            pc    <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc    <= pc_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/nf_i_fu.sv
// Instruction fetch unit: one outstanding read, zero-wait throughput of one
// instruction per cycle, single-entry skid buffer for decode stalls and a
// redirect (pc_src) that flushes everything.
//   clk, reset          : clock, synchronous active-high reset
//   addr_i, req_i       : instruction memory request (registered, from pc/state)
//   req_ack_i, rd_i     : memory accept and same-cycle read data
//   pc_src, pc_branch   : redirect strobe and target
//   stall_if            : decode not accepting
//   instr_if, pc_if     : instruction and its address to decode
//   instr_vld           : instr_if is a real fetched instruction
module nf_i_fu
    import nf_i_fu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_C,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] addr_i,
    output logic        req_i,
    input  logic        req_ack_i,
    input  logic [31:0] rd_i,
    input  logic        pc_src,
    input  logic [31:0] pc_branch,
    input  logic        stall_if,
    output logic [31:0] instr_if,
    output logic [31:0] pc_if,
    output logic        instr_vld
);

    fu_state_t   state;
    logic [31:0] pc;

    logic        skid_load;
    logic        skid_clear;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        skid_valid;

    // Memory side comes only from registers: no path from pc_src/pc_branch.
    assign addr_i = pc;
    assign req_i  = (state == REQ);

    assign skid_load  = !reset && !pc_src && (state == REQ) && req_ack_i && stall_if;
    assign skid_clear = reset || pc_src || ((state == HOLD) && !stall_if);

    nf_i_fu_skid u_skid (
        .clk      (clk),
        .clear    (skid_clear),
        .load     (skid_load),
        .instr_in (rd_i),
        .pc_in    (pc),
        .instr    (skid_instr),
        .pc       (skid_pc),
        .valid    (skid_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= REQ;
            pc        <= RESET_PC;
            instr_if  <= NOP_INSTR;
            pc_if     <= RESET_PC;
            instr_vld <= 1'b0;
        end else if (pc_src) begin
            // Flush beats stall and any same-cycle ack.
            state     <= REQ;
            pc        <= word_align(pc_branch);
            instr_if  <= NOP_INSTR;
            instr_vld <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (req_ack_i) begin
                        pc <= pc + 32'd4;
                        if (stall_if) begin
                            state <= HOLD;
                        end else begin
                            instr_if  <= rd_i;
                            pc_if     <= pc;
                            instr_vld <= 1'b1;
                        end
                    end else if (!stall_if) begin
                        instr_if  <= NOP_INSTR;
                        instr_vld <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_if) begin
                        instr_if  <= skid_instr;
                        pc_if     <= skid_pc;
                        instr_vld <= skid_valid;
                        state     <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_nf_i_fu.sv
// Bench for nf_i_fu: directed cycles push expected {instr, pc} into a queue;
// a monitor pops whenever decode sees a newly presented valid instruction.
module tb_nf_i_fu;
    import nf_i_fu_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] addr_i;
    logic        req_i;
    logic        req_ack_i;
    logic [31:0] rd_i;
    logic        pc_src;
    logic [31:0] pc_branch;
    logic        stall_if;
    logic [31:0] instr_if;
    logic [31:0] pc_if;
    logic        instr_vld;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];
    logic        last_stall = 1'b0;

    nf_i_fu #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr_i    (addr_i),
        .req_i     (req_i),
        .req_ack_i (req_ack_i),
        .rd_i      (rd_i),
        .pc_src    (pc_src),
        .pc_branch (pc_branch),
        .stall_if  (stall_if),
        .instr_if  (instr_if),
        .pc_if     (pc_if),
        .instr_vld (instr_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stall value in force at the edge that just happened.
    always @(posedge clk) last_stall = stall_if;

    // New valid word appears only after an edge with stall_if low.
    always @(negedge clk) begin
        if (!reset && instr_vld && !last_stall) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL monitor_unexpected: got instr=%h pc=%h, required none", instr_if, pc_if);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({instr_if, pc_if} !== e) begin
                    n_bad++;
                    $display("FAIL monitor_word: got instr=%h pc=%h, required instr=%h pc=%h",
                             instr_if, pc_if, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs; optionally record the word decode must see.
    task automatic drive(input logic ack, input logic stall, input logic src,
                         input logic [31:0] br, input logic [31:0] data,
                         input logic push, input logic [31:0] exp_pc);
        req_ack_i = ack;
        stall_if  = stall;
        pc_src    = src;
        pc_branch = br;
        rd_i      = data;
        if (push) exp_q.push_back({data, exp_pc});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_ack_i = 1'b0; rd_i = '0; pc_src = 1'b0;
        pc_branch = '0; stall_if = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_instr", instr_if, NOP);
        chk("reset_vld",   {31'd0, instr_vld}, 32'd0);
        chk("reset_pc_if", pc_if, 32'h0);
        reset = 1'b0;
        chk("post_reset_req",  {31'd0, req_i}, 32'd1);
        chk("post_reset_addr", addr_i, 32'h0);

        // Zero-wait streaming
        drive(1, 0, 0, 0, 32'h0010_0093, 1, 32'h0);
        chk("stream_addr4", addr_i, 32'h4);
        chk("stream_vld",   {31'd0, instr_vld}, 32'd1);
        drive(1, 0, 0, 0, 32'h0010_0094, 1, 32'h4);
        chk("stream_addr8", addr_i, 32'h8);
        chk("stream_instr", instr_if, 32'h0010_0094);

        // Ack withheld three cycles at address 8
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 32'hBAD0_0000, 0, 0);
            chk("wait_addr",  addr_i, 32'h8);
            chk("wait_req",   {31'd0, req_i}, 32'd1);
            chk("wait_vld",   {31'd0, instr_vld}, 32'd0);
            chk("wait_instr", instr_if, NOP);
        end
        drive(1, 0, 0, 0, 32'h0010_0095, 1, 32'h8);
        chk("resume_addr", addr_i, 32'hC);

        // Stall with ack at address 4
        drive(0, 0, 1, 32'h0, 32'h0, 0, 0);
        chk("redir0_addr", addr_i, 32'h0);
        drive(1, 0, 0, 0, 32'hA000_0000, 1, 32'h0);
        drive(1, 1, 0, 0, 32'hA000_0004, 1, 32'h4);
        chk("stall_req",    {31'd0, req_i}, 32'd0);
        chk("stall_instr",  instr_if, 32'hA000_0000);
        chk("stall_pc_if",  pc_if, 32'h0);
        drive(0, 1, 0, 0, 32'h0, 0, 0);
        chk("hold_req",     {31'd0, req_i}, 32'd0);
        chk("hold_instr",   instr_if, 32'hA000_0000);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        chk("release_instr", instr_if, 32'hA000_0004);
        chk("release_pc_if", pc_if, 32'h4);
        chk("release_addr",  addr_i, 32'h8);
        chk("release_req",   {31'd0, req_i}, 32'd1);

        // Redirect coincident with ack: data dropped, target aligned
        drive(1, 0, 1, 32'h0000_0103, 32'hDEAD_BEEF, 0, 0);
        chk("redir_instr", instr_if, NOP);
        chk("redir_vld",   {31'd0, instr_vld}, 32'd0);
        chk("redir_addr",  addr_i, 32'h100);
        drive(1, 0, 0, 0, 32'hB000_0100, 1, 32'h100);
        chk("redir_next",  addr_i, 32'h104);

        // Wrap at top of address space
        drive(0, 0, 1, 32'hFFFF_FFFC, 32'h0, 0, 0);
        chk("wrap_addr0", addr_i, 32'hFFFF_FFFC);
        drive(1, 0, 0, 0, 32'hC000_FFFC, 1, 32'hFFFF_FFFC);
        chk("wrap_addr1", addr_i, 32'h0);
        drive(1, 0, 0, 0, 32'hC000_0000, 1, 32'h0);
        chk("wrap_addr2", addr_i, 32'h4);

        // Flush overrides stall
        drive(0, 1, 1, 32'h200, 32'h0, 0, 0);
        chk("flush_stall_instr", instr_if, NOP);
        chk("flush_stall_vld",   {31'd0, instr_vld}, 32'd0);
        chk("flush_stall_addr",  addr_i, 32'h200);

        // Reset during HOLD drops the parked word
        drive(1, 1, 0, 0, 32'hEEEE_0200, 0, 0);
        chk("hold2_req", {31'd0, req_i}, 32'd0);
        reset = 1'b1;
        drive(1, 1, 0, 0, 32'hEEEE_0204, 0, 0);
        chk("rst_hold_instr", instr_if, NOP);
        chk("rst_hold_vld",   {31'd0, instr_vld}, 32'd0);
        chk("rst_hold_pc_if", pc_if, 32'h0);
        chk("rst_hold_req",   {31'd0, req_i}, 32'd1);
        chk("rst_hold_addr",  addr_i, 32'h0);
        reset = 1'b0;
        drive(1, 0, 0, 0, 32'hF000_0000, 1, 32'h0);
        chk("after_rst_addr", addr_i, 32'h4);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
